fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Sequences the single-port camera frame buffer. The buffer does one access per clk: a write when we=1, otherwise a registered read.
- Shares that port between two streams: the CSI-2 pixel write stream, which can never stall, and the display read stream, which is prefetched into a small internal FIFO.
- Sits between the CSI-2 byte/pixel unpacker and the video output timing block.
- Generates all buffer addresses and handles frame wrap.

Parameters:
- ADDR_W, 20, buffer address width.
- DATA_W, 8, pixel width.
- FRAME_PIXELS, 307200, pixels per frame (640x480); addresses run 0..FRAME_PIXELS-1.
- FIFO_DEPTH, 16, read prefetch FIFO entries (power of 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  camera pixel present this cycle (no backpressure).
- wr_sof  in  1  camera start-of-frame, qualifies the pixel on wr_valid.
- wr_data  in  DATA_W  camera pixel.
- rd_sof  in  1  display start-of-frame: flush and restart the read address.
- rd_ready  in  1  display pops one pixel.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  DATA_W  FIFO head pixel.
- underrun  out  1  sticky: rd_ready seen while rd_valid=0.
- frame_ready  out  1  at least one full frame has been written.
- buf_we  out  1  to buffer we.
- buf_addr_in  out  ADDR_W  to buffer addr_in.
- buf_addr_out  out  ADDR_W  to buffer addr_out.
- buf_data_in  out  DATA_W  to buffer data_in.
- buf_data_out  in  DATA_W  from buffer; valid 1 cycle after a read cycle (we=0).

Behaviour:
- Reset (rst_n=0 at posedge): wr_addr=0, rd_addr=0, FIFO empty, no reads in flight. Outputs: rd_valid=0, rd_data=0, underrun=0, frame_ready=0, buf_we=0, buf_addr_in=0, buf_addr_out=0, buf_data_in=0. FSM enters WAIT_FRAME.
- Buffer port outputs are combinational from the current-cycle arbitration decision. Buffer captures on the same edge.
- Write path:
  - wr_valid=1 -> buf_we=1, buf_data_in=wr_data, buf_addr_in = wr_sof ? 0 : wr_addr.
  - Next wr_addr = buf_addr_in+1, wrapping FRAME_PIXELS-1 -> 0.
  - wr_valid=0 -> wr_addr holds; wr_sof is ignored.
  - Writes always win arbitration, zero latency.
- Read issue: a read is issued in a cycle when all of the following hold:
  - wr_valid=0;
  - FSM in RUN;
  - rd_sof=0;
  - (fifo_count + inflight) < FIFO_DEPTH.
- On a read: buf_we=0, buf_addr_out=rd_addr, inflight set. Next rd_addr = rd_addr+1, wrapping at FRAME_PIXELS-1 -> 0.
- buf_addr_out holds its last value when no read is issued.
- Read return: in the cycle after an issue, buf_data_out is pushed into the FIFO. Issue-to-rd_valid latency is 2 clk on an empty FIFO.
- FIFO: standard FWFT.
  - rd_valid=(count!=0); rd_data is the head entry.
  - Pop when rd_ready & rd_valid.
  - Simultaneous push and pop is legal; count is unchanged.
  - Never overflows, by the issue rule.
- underrun: set when rd_ready=1 & rd_valid=0 in RUN; cleared only by rd_sof or reset.
- rd_sof:
  - Flushes the FIFO (count=0, rd_valid=0 next cycle) and sets rd_addr=0.
  - Discards any read returning the following cycle (inflight dropped).
  - Clears underrun.
  - A rd_ready in the same cycle is ignored.
  - The first new read issues the cycle after rd_sof, at address 0.
- FSM:
  - WAIT_FRAME: no reads issued and no underrun flagging. Moves to RUN on the cycle a write lands at address FRAME_PIXELS-1.
  - RUN: frame_ready=1. Stays in RUN until reset.
- Simultaneous wr_sof and frame wrap: the explicit wr_sof to 0 wins.
- Reset mid-frame: all state is discarded and the block returns to WAIT_FRAME. Buffer contents are untouched but treated as invalid.
- Throughput: read bandwidth = cycles with wr_valid=0. The display must consume at most that rate or underrun flags.

Test Plan:
- Reset: hold rst_n=0 3 cycles with wr_valid=1 -> buf_we=0, all outputs 0, no buffer access.
- First frame: wr_sof+wr_valid then 307199 further pixels (data=addr[7:0]) -> buf_addr_in 0..307199. frame_ready rises the cycle after the write to 307199. No read issued before that.
- Prefetch: RUN, wr_valid=0, rd_ready=0 -> reads at addr 0..15, rd_valid 2 cycles after the first issue, FIFO fills to 16, issuing stops. Then rd_ready=1 continuously -> rd_data 0,1,2,... with no gap.
- Collision: RUN, wr_valid toggles 1/0 every cycle, rd_ready=1 -> writes never delayed; reads only on wr_valid=0 cycles. Data stays in order; underrun sets after the initial FIFO drains.
- Wrap: rd_addr=307198, keep popping -> reads 307198, 307199, 0, 1. Same check for wr_addr at 307199 -> 0.
- rd_sof mid-stream with a read in flight and FIFO=10 -> next cycle rd_valid=0 and underrun=0. The in-flight datum is dropped, the next issue is addr 0, and the first popped pixel equals buffer[0].

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_fifo: first-word-fall-through prefetch queue with synchronous flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller never pushes into a full queue.
module fb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     out_vld,
  output logic [W-1:0]             out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_vld & ~flush;
    do_pop   = pop_rdy & (cnt_q != '0) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; the head is only meaningful while out_vld is set.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign out_vld = (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = cnt_q;
endmodule

// fb_arbiter: shares the single-port frame buffer between camera writes and display prefetch reads.
// Latency: writes reach the buffer in the same cycle; read issue to rd_valid is 2 clk on an empty FIFO.
// Backpressure: camera writes are never stalled; reads only use idle cycles, underrun flags if the display outruns them.
module fb_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_sof,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              underrun,
  output logic              frame_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr_in,
  output logic [ADDR_W-1:0] buf_addr_out,
  output logic [DATA_W-1:0] buf_data_in,
  input  logic [DATA_W-1:0] buf_data_out
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] buf_addr_out_q, buf_addr_out_d;
  logic              inflight_q, inflight_d;
  logic              underrun_q, underrun_d;

  logic [ADDR_W-1:0] wr_addr_sel;
  logic              wr_vld, rd_issue_vld, run;
  logic              fifo_push_vld, fifo_pop_rdy, fifo_vld;
  logic [DATA_W-1:0] fifo_dat;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    run            = (state_q == RUN);
    wr_vld         = rst_n & wr_valid;
    wr_addr_sel    = wr_sof ? '0 : wr_addr_q;
    wr_addr_d      = wr_addr_q;
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    buf_addr_out_d = buf_addr_out_q;

    if (wr_vld) begin
      wr_addr_d = (wr_addr_sel == LAST_ADDR) ? '0 : wr_addr_sel + ADDR_W'(1);
      if (!run && wr_addr_sel == LAST_ADDR) state_d = RUN;
    end

    // Occupancy counts the outstanding read so the FIFO can never overflow.
    rd_issue_vld = rst_n && !wr_valid && run && !rd_sof &&
                   ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    inflight_d   = rd_issue_vld;

    if (rd_sof) begin
      rd_addr_d = '0;
    end else if (rd_issue_vld) begin
      rd_addr_d      = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
      buf_addr_out_d = rd_addr_q;
    end

    fifo_push_vld = inflight_q & ~rd_sof;
    fifo_pop_rdy  = rd_ready & fifo_vld & ~rd_sof;
    underrun_d    = rd_sof ? 1'b0 : (underrun_q | (run & rd_ready & ~fifo_vld));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= WAIT_FRAME;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      buf_addr_out_q <= '0;
      inflight_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      buf_addr_out_q <= buf_addr_out_d;
      inflight_q     <= inflight_d;
      underrun_q     <= underrun_d;
    end
  end

  fb_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (rd_sof),
    .push_vld (fifo_push_vld),
    .push_dat (buf_data_out),
    .pop_rdy  (fifo_pop_rdy),
    .out_vld  (fifo_vld),
    .out_dat  (fifo_dat),
    .count    (fifo_count)
  );

  assign buf_we       = wr_vld;
  assign buf_addr_in  = wr_vld ? wr_addr_sel : '0;
  assign buf_data_in  = wr_vld ? wr_data : '0;
  assign buf_addr_out = rst_n ? buf_addr_out_d : '0;
  assign rd_valid     = fifo_vld;
  assign rd_data      = fifo_vld ? fifo_dat : '0;
  assign underrun     = underrun_q;
  assign frame_ready  = run;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a small frame and a registered-read buffer model.
module tb_fb_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int FP     = 48;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid, wr_sof, rd_sof, rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, underrun, frame_ready, buf_we;
  logic [DATA_W-1:0] rd_data, buf_data_in;
  logic [DATA_W-1:0] buf_data_out;
  logic [ADDR_W-1:0] buf_addr_in, buf_addr_out;

  logic [DATA_W-1:0] mem [64];

  int n_total = 0;
  int n_pass  = 0;
  int wa;
  int exp_pop;

  fb_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_sof       (wr_sof),
    .wr_data      (wr_data),
    .rd_sof       (rd_sof),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .underrun     (underrun),
    .frame_ready  (frame_ready),
    .buf_we       (buf_we),
    .buf_addr_in  (buf_addr_in),
    .buf_addr_out (buf_addr_out),
    .buf_data_in  (buf_data_in),
    .buf_data_out (buf_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_we) mem[buf_addr_in[5:0]] <= buf_data_in;
    else        buf_data_out <= mem[buf_addr_out[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next cycle and apply that cycle's inputs away from the edge.
  task automatic drive(input logic wv, input logic sof, input logic [7:0] wd,
                       input logic rs, input logic rr);
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_sof   = sof;
    wr_data  = wd;
    rd_sof   = rs;
    rd_ready = rr;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_sof   = 1'b0;
    wr_data  = 8'hAA;
    rd_sof   = 1'b0;
    rd_ready = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_buf_we",       32'(buf_we),       32'd0);
    chk("rst_buf_addr_in",  32'(buf_addr_in),  32'd0);
    chk("rst_buf_data_in",  32'(buf_data_in),  32'd0);
    chk("rst_buf_addr_out", 32'(buf_addr_out), 32'd0);
    chk("rst_rd_valid",     32'(rd_valid),     32'd0);
    chk("rst_rd_data",      32'(rd_data),      32'd0);
    chk("rst_underrun",     32'(underrun),     32'd0);
    chk("rst_frame_ready",  32'(frame_ready),  32'd0);
    rst_n    = 1'b1;
    wr_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      chk("pre_sof_addr", 32'(buf_addr_in), 32'(i));
    end

    // First frame, restarted at address 0 by wr_sof.
    for (int i = 0; i < FP; i++) begin
      drive(1'b1, (i == 0), 8'(i), 1'b0, 1'b0);
      chk("frame_we",      32'(buf_we),      32'd1);
      chk("frame_addr_in", 32'(buf_addr_in), 32'(i));
      chk("frame_data_in", 32'(buf_data_in), 32'(i));
      if (i == FP - 1) begin
        chk("frame_ready_before_last", 32'(frame_ready), 32'd0);
        chk("frame_no_read_valid",     32'(rd_valid),    32'd0);
      end
    end

    // Prefetch: reads at 0..DEPTH-1, then issuing stops with a full FIFO.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (k == 0) chk("frame_ready_run", 32'(frame_ready), 32'd1);
      chk("pf_we",       32'(buf_we),       32'd0);
      chk("pf_addr_out", 32'(buf_addr_out), (k < DEPTH) ? 32'(k) : 32'(DEPTH - 1));
      chk("pf_rd_valid", 32'(rd_valid),     (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("pf_rd_data", 32'(rd_data), 32'd0);
    end

    // Continuous drain with no gap.
    for (int p = 0; p < 40; p++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data",  32'(rd_data),  32'(p));
    end
    exp_pop = 40;

    // Collision: writes every other cycle, reads get the gaps, display pops every cycle.
    wa = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 2 == 0) begin
        drive(1'b1, 1'b0, 8'(wa), 1'b0, 1'b1);
        chk("col_we",      32'(buf_we),      32'd1);
        chk("col_addr_in", 32'(buf_addr_in), 32'(wa));
        wa = (wa + 1) % FP;
      end else begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("col_rd_cycle_we", 32'(buf_we), 32'd0);
      end
      if (c == 0) chk("col_underrun_clear", 32'(underrun), 32'd0);
      if (rd_valid) begin
        chk("col_data", 32'(rd_data), 32'(exp_pop));
        exp_pop = (exp_pop + 1) % FP;
      end
    end
    chk("col_underrun_set", 32'(underrun), 32'd1);
    chk("col_popped_past_wrap", 32'(exp_pop < 40), 32'd1);

    // First rd_sof: flush, clear underrun, restart at 0.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("sof1_valid",    32'(rd_valid),     32'd0);
    chk("sof1_underrun", 32'(underrun),     32'd0);
    chk("sof1_addr_out", 32'(buf_addr_out), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sof1_underrun_reset", 32'(underrun),     32'd1);
    chk("sof1_addr_out_1",     32'(buf_addr_out), 32'd1);
    for (int k = 3; k < 12; k++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_valid",    32'(rd_valid),     32'd1);
    chk("fill_head",     32'(rd_data),      32'd0);
    chk("fill_addr_out", 32'(buf_addr_out), 32'd10);

    // Second rd_sof with FIFO=10 and the read of address 10 in flight.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sof2_valid",    32'(rd_valid),     32'd0);
    chk("sof2_underrun", 32'(underrun),     32'd0);
    chk("sof2_addr_out", 32'(buf_addr_out), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sof2_inflight_dropped", 32'(rd_valid),     32'd0);
    chk("sof2_addr_out_1",       32'(buf_addr_out), 32'd1);
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("sof2_pop_valid", 32'(rd_valid), 32'd1);
      chk("sof2_pop_data",  32'(rd_data),  32'(mem[p]));
      chk("sof2_pop_order", 32'(rd_data),  32'(p));
    end

    // Reset mid-stream returns to WAIT_FRAME.
    drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(buf_we), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("mid_rst_valid",       32'(rd_valid),    32'd0);
    chk("mid_rst_underrun",    32'(underrun),    32'd0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("wait_no_reads",    32'(rd_valid),     32'd0);
    chk("wait_addr_out",    32'(buf_addr_out), 32'd0);
    chk("wait_no_underrun", 32'(underrun),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
